// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair comparator: measures two mux-selected oscillators and emits one PUF response bit.
// Latency: done pulses 2*(SETTLE+WINDOW)+2 cycles after the accepted start edge.
// Backpressure: none; start is only honoured in IDLE and is ignored while a measurement runs.
// Optional feature macro: RO_CMP_TIE_FLAG_EN adds a registered 'tie' output (count_a == count_b).
module ro_pair_compare #(
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       challenge,
  input  logic             ro_in,
  output logic [3:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`ifdef RO_CMP_TIE_FLAG_EN
  ,
  output logic             tie
`endif
);

  localparam int MAXLEN = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW     = $clog2(MAXLEN + 1);
  localparam logic [TW-1:0]    WIN_M1 = TW'(WINDOW - 1);
  localparam logic [TW-1:0]    SET_M1 = TW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CMAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE_A, S_COUNT_A, S_SETTLE_B, S_COUNT_B, S_COMPARE, S_DONE
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [3:0]       chal_b;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             s1, s2, s3;
  logic             edge_p;

  // Two-flop synchronizer for the asynchronous oscillator, plus a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_p = s2 & ~s3;

  // Measurement sequencer: settle/count A, settle/count B, compare, then a one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      chal_b   <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= 1'b0;
      count_a  <= '0;
      count_b  <= '0;
`ifdef RO_CMP_TIE_FLAG_EN
      tie      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chal_b <= challenge[3:0];
            sel    <= challenge[7:4];
            cnt_a  <= '0;
            timer  <= SET_M1;
            busy   <= 1'b1;
            state  <= S_SETTLE_A;
          end
        end
        S_SETTLE_A: begin
          if (timer == '0) begin
            timer <= WIN_M1;
            state <= S_COUNT_A;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COUNT_A: begin
          if (edge_p && (cnt_a != CMAX)) cnt_a <= cnt_a + 1'b1;
          if (timer == '0) begin
            // Switch the mux now; SETTLE >= 3 flushes stale samples of A out of the synchronizer.
            sel   <= chal_b;
            cnt_b <= '0;
            timer <= SET_M1;
            state <= S_SETTLE_B;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_SETTLE_B: begin
          if (timer == '0) begin
            timer <= WIN_M1;
            state <= S_COUNT_B;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COUNT_B: begin
          if (edge_p && (cnt_b != CMAX)) cnt_b <= cnt_b + 1'b1;
          if (timer == '0) begin
            state <= S_COMPARE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COMPARE: begin
          response <= (cnt_a > cnt_b);
          count_a  <= cnt_a;
          count_b  <= cnt_b;
`ifdef RO_CMP_TIE_FLAG_EN
          tie      <= (cnt_a == cnt_b);
`endif
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_pair_compare.sv
// Bench for ro_pair_compare: 16 modelled oscillators behind the select, scoreboard of expected results.
// Main instance uses WINDOW=64/SETTLE=4; a second CNT_W=4/WINDOW=128 instance exercises saturation.
// Expected results are queued when start is driven and compared when done pulses.
module tb_ro_pair_compare;

  localparam int W0  = 64;
  localparam int S0  = 4;
  localparam int LAT = 2 * (S0 + W0) + 2;
  localparam int W1  = 128;
  localparam int LAT1 = 2 * (S0 + W1) + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  challenge0 = '0, challenge1 = '0;
  logic        ro0, ro1;
  logic [3:0]  sel0, sel1;
  logic        busy0, busy1, done0, done1, resp0, resp1;
  logic [15:0] ca0, cb0;
  logic [3:0]  ca1, cb1;
`ifdef RO_CMP_TIE_FLAG_EN
  logic        tie0, tie1;
`endif

  logic [15:0] osc = '0;
  int          per [16];
  int          tick = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;

  typedef struct {
    int ea;
    int eb;
    int er;
    int et;
    int st;
  } sb_t;

  sb_t q [$];

  ro_pair_compare #(.WINDOW(W0), .SETTLE(S0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .challenge(challenge0), .ro_in(ro0),
    .sel(sel0), .busy(busy0), .done(done0), .response(resp0),
    .count_a(ca0), .count_b(cb0)
`ifdef RO_CMP_TIE_FLAG_EN
    , .tie(tie0)
`endif
  );

  ro_pair_compare #(.WINDOW(W1), .SETTLE(S0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .challenge(challenge1), .ro_in(ro1),
    .sel(sel1), .busy(busy1), .done(done1), .response(resp1),
    .count_a(ca1), .count_b(cb1)
`ifdef RO_CMP_TIE_FLAG_EN
    , .tie(tie1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator bank: square waves with periods in clk cycles, advanced off the active edge.
  always @(negedge clk) begin
    tick = tick + 1;
    for (int k = 0; k < 16; k++) osc[k] = ((tick % per[k]) < (per[k] / 2));
  end

  assign ro0 = osc[sel0];
  assign ro1 = osc[sel1];

  task automatic chk(input string tag, input int got, input int exp);
    tot_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else pass_cnt++;
  endtask

  function automatic int near(input int got, input int exp);
    return ((got - exp) >= -1 && (got - exp) <= 1) ? 1 : 0;
  endfunction

  // Scoreboard for the main instance: every done pops one expected entry.
  always @(negedge clk) begin
    sb_t e;
    if (done0) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done_queue_size", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.st + 1, LAT);
        chk($sformatf("count_a=%0d_near_%0d", ca0, e.ea), near(int'(ca0), e.ea), 1);
        chk($sformatf("count_b=%0d_near_%0d", cb0, e.eb), near(int'(cb0), e.eb), 1);
        chk("response", int'(resp0), e.er);
`ifdef RO_CMP_TIE_FLAG_EN
        if (e.et >= 0) chk("tie", int'(tie0), e.et);
`endif
      end
    end
  end

  task automatic run(input logic [7:0] ch, input int ea, input int eb, input int er,
                     input int et, input bit inj, input bit abort);
    int dc0;
    int n;
    sb_t e;
    @(negedge clk);
    start0 = 1'b1;
    challenge0 = ch;
    @(posedge clk);
    #1;
    e.ea = ea; e.eb = eb; e.er = er; e.et = et; e.st = cyc;
    q.push_back(e);
    start0 = 1'b0;
    challenge0 = 8'($urandom);
    dc0 = done_cnt;
    repeat (29) @(posedge clk);
    @(negedge clk);
    chk("sel_during_a", int'(sel0), int'(ch[7:4]));
    chk("busy_during_run", int'(busy0), 1);
    if (inj) begin
      start0 = 1'b1;
      challenge0 = 8'hFF;
      @(negedge clk);
      start0 = 1'b0;
    end
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk("sel_during_b", int'(sel0), int'(ch[3:0]));
    if (abort) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_sel", int'(sel0), 0);
      chk("abort_busy", int'(busy0), 0);
      chk("abort_done", int'(done0), 0);
      chk("abort_response", int'(resp0), 0);
      rst = 1'b0;
      void'(q.pop_back());
      repeat (200) @(posedge clk);
      chk("no_done_after_abort", done_cnt, dc0);
    end else begin
      n = 0;
      while (q.size() != 0 && n < 400) begin
        @(posedge clk);
        n++;
      end
      chk("scoreboard_drained", q.size(), 0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("single_done", done_cnt, dc0 + 1);
      chk("idle_after_done", int'(busy0), 0);
    end
  endtask

  initial begin
    int n;
    int t0;
    for (int k = 0; k < 16; k++) per[k] = 10;
    per[1] = 8;
    per[2] = 16;
    per[3] = 4;
    per[5] = 4;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", int'(sel0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_response", int'(resp0), 0);
    chk("rst_count_a", int'(ca0), 0);
    chk("rst_count_b", int'(cb0), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // A faster than B, then swapped, then the same oscillator twice.
    run(8'h12, 8, 4, 1, 0, 1'b0, 1'b0);
    run(8'h21, 4, 8, 0, 0, 1'b0, 1'b0);
    run(8'h33, 16, 16, 0, 1, 1'b0, 1'b0);
    // Stray start during COUNT_A is ignored.
    run(8'h12, 8, 4, 1, 0, 1'b1, 1'b0);
    // Reset during COUNT_B aborts without a done.
    run(8'h12, 8, 4, 1, 0, 1'b0, 1'b1);
    // Results survive into the following run until its compare.
    run(8'h21, 4, 8, 0, 0, 1'b0, 1'b0);

    // Saturation on the narrow-counter instance.
    @(negedge clk);
    start1 = 1'b1;
    challenge1 = 8'h55;
    @(posedge clk);
    #1;
    t0 = cyc;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done_seen", int'(done1), 1);
    chk("sat_latency", cyc - t0 + 1, LAT1);
    chk("sat_count_a", int'(ca1), 15);
    chk("sat_count_b", int'(cb1), 15);
    chk("sat_response", int'(resp1), 0);
`ifdef RO_CMP_TIE_FLAG_EN
    chk("sat_tie", int'(tie1), 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
